// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a single UART TX byte port.
// Packets are atomic; owners alternate round-robin, an idle gap follows
// every packet, and a watchdog frees the port if the owner stalls.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int unsigned CntRange  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntRangeC = (CntRange < 2) ? 2 : CntRange;
  localparam int unsigned CntW      = $clog2(CntRangeC);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLock, StGap} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_owner_q, last_owner_d;  // 0 = req0, 1 = req1
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0]   gap_cnt_q, gap_cnt_d;

  logic              owner_valid;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic              pick_req1;
  logic              pkt_done;

  // Select the current owner's request signals.
  always_comb begin
    if (grant_q[1]) begin
      owner_valid = req1_valid;
      owner_data  = req1_data;
      owner_last  = req1_last;
    end else begin
      owner_valid = req0_valid;
      owner_data  = req0_data;
      owner_last  = req0_last;
    end
  end

  // On a tie the requester that did not own the last packet wins.
  assign pick_req1 = req1_valid & (~req0_valid | ~last_owner_q);

  // Next-state, counters and pass-through outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    stall_cnt_d  = stall_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tx_valid     = 1'b0;
    tx_data      = '0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    timeout_err  = 1'b0;
    pkt_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          grant_d     = pick_req1 ? 2'b10 : 2'b01;
          stall_cnt_d = '0;
          state_d     = StLock;
        end
      end

      StLock: begin
        tx_valid   = owner_valid;
        tx_data    = owner_data;
        req0_ready = ~grant_q[1] & tx_ready;
        req1_ready =  grant_q[1] & tx_ready;
        if (owner_valid && tx_ready) begin
          stall_cnt_d = '0;
          pkt_done    = owner_last;
        end else if (!owner_valid) begin
          // Only owner-not-valid cycles count; backpressure never does.
          if (stall_cnt_q >= TimeoutLast) begin
            timeout_err = 1'b1;
            pkt_done    = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        if (pkt_done) begin
          last_owner_d = grant_q[1];
          grant_d      = 2'b00;
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end

      StGap: begin
        if (gap_cnt_q >= GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and counter registers; reset returns to idle with req0 favoured.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      stall_cnt_q  <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      stall_cnt_q  <= stall_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with default parameters
// (DATA_W=8, GAP_CYCLES=16, TIMEOUT=1024).
module tb_uart_tx_arbiter;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk_clk = ~clk_clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    tx_ready   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_reset = 1'b1;
    step();
    step();
    reset_reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_reset = 1'b1;
    req0_valid  = 1'b1;
    tx_ready    = 1'b1;
    #2;
    n_checks++;
    if ({grant, tx_valid, req0_ready, req1_ready, timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {grant, tx_valid, req0_ready, req1_ready, timeout_err});
    end
    step();
    reset_reset = 1'b0;
    #1;
    n_checks++;
    if ({grant, tx_valid, req0_ready, req1_ready, tx_data} !== 13'b0) begin
      n_fail++;
      $display("FAIL first_cycle_after_release: got %h expected 0",
               {grant, tx_valid, req0_ready, req1_ready, tx_data});
    end
    step();
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_then_grant: got %b expected 01", grant);
    end
  endtask

  task automatic test_single_packet();
    int bad;
    int cnt;
    do_reset();
    tx_ready   = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'hA0;
    #1;
    n_checks++;
    if (grant !== 2'b00 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_idle_before_grant: got grant=%b tx_valid=%b expected 00/0",
               grant, tx_valid);
    end
    step();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      req0_data = 8'hA0 + 8'(i);
      req0_last = (i == 3);
      #1;
      if (grant !== 2'b01 || tx_valid !== 1'b1 || req0_ready !== 1'b1 ||
          tx_data !== 8'hA0 + 8'(i)) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pkt_four_transfers: got %0d bad beats expected 0", bad);
    end
    // Hold a new request through the gap: 16 gap cycles plus 1 arbitration cycle.
    req0_last = 1'b0;
    req0_data = 8'hB0;
    cnt = 0;
    bad = 0;
    while (grant === 2'b00 && cnt < 100) begin
      if (tx_valid !== 1'b0 || req0_ready !== 1'b0) bad++;
      step();
      cnt++;
    end
    n_checks++;
    if (cnt != 17) begin
      n_fail++;
      $display("FAIL pkt_gap_length: got %0d idle cycles expected 17", cnt);
    end
    n_checks++;
    if (bad != 0 || grant !== 2'b01) begin
      n_fail++;
      $display("FAIL pkt_gap_outputs: got bad=%0d grant=%b expected 0/01", bad, grant);
    end
  endtask

  task automatic test_alternation();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    int cnt;
    do_reset();
    tx_ready   = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (k % 2 == 0) ? 8'h11 : 8'h22;
      cnt = 0;
      while (grant === 2'b00 && cnt < 100) begin
        step();
        cnt++;
      end
      #1;
      n_checks++;
      if (grant !== exp_g || tx_data !== exp_d) begin
        n_fail++;
        $display("FAIL alternation_%0d: got grant=%b data=%h expected %b/%h",
                 k, grant, tx_data, exp_g, exp_d);
      end
      step();
    end
  endtask

  task automatic test_no_preempt();
    int cnt;
    do_reset();
    tx_ready   = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hB0; req1_last = 1'b0;
    step();
    #1;
    n_checks++;
    if (grant !== 2'b10 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nopre_grant: got grant=%b r1=%b r0=%b expected 10/1/0",
               grant, req1_ready, req0_ready);
    end
    step();
    req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
    for (int i = 1; i < 3; i++) begin
      req1_data = 8'hB0 + 8'(i);
      req1_last = (i == 2);
      #1;
      n_checks++;
      if (grant !== 2'b10 || req0_ready !== 1'b0 || tx_data !== 8'hB0 + 8'(i)) begin
        n_fail++;
        $display("FAIL nopre_beat_%0d: got grant=%b r0=%b data=%h expected 10/0/%h",
                 i, grant, req0_ready, tx_data, 8'hB0 + 8'(i));
      end
      step();
    end
    req1_valid = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL nopre_release: got %b expected 00", grant);
    end
    cnt = 0;
    while (grant === 2'b00 && cnt < 100) begin
      step();
      cnt++;
    end
    n_checks++;
    if (grant !== 2'b01 || cnt != 17) begin
      n_fail++;
      $display("FAIL nopre_req0_after: got grant=%b wait=%0d expected 01/17", grant, cnt);
    end
  endtask

  task automatic test_timeout();
    int tcount;
    int first_idx;
    logic [1:0] g_after;
    int cnt;
    do_reset();
    tx_ready   = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h33; req0_last = 1'b0;
    step();
    step();
    req0_valid = 1'b0;
    tcount    = 0;
    first_idx = -1;
    g_after   = 2'b11;
    for (int i = 0; i < 1100; i++) begin
      #1;
      if (timeout_err === 1'b1) begin
        tcount++;
        if (first_idx < 0) first_idx = i;
      end
      if (i == 1024) g_after = grant;
      step();
    end
    n_checks++;
    if (tcount != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: got %0d cycles expected 1", tcount);
    end
    n_checks++;
    if (first_idx != 1023) begin
      n_fail++;
      $display("FAIL timeout_position: got %0d expected 1023", first_idx);
    end
    n_checks++;
    if (g_after !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_grant_drop: got %b expected 00", g_after);
    end
    req0_valid = 1'b1; req0_last = 1'b1;
    req1_valid = 1'b1; req1_last = 1'b1; req1_data = 8'h44;
    cnt = 0;
    while (grant === 2'b00 && cnt < 100) begin
      step();
      cnt++;
    end
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_next_tie: got %b expected 10", grant);
    end
  endtask

  task automatic test_ready_stall();
    int bad;
    do_reset();
    tx_ready   = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      #1;
      if (timeout_err !== 1'b0 || tx_valid !== 1'b1 || grant !== 2'b01 ||
          req0_ready !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_no_timeout: got %0d bad cycles expected 0", bad);
    end
    tx_ready = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || tx_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL stall_byte_offer: got ready=%b data=%h expected 1/5a", req0_ready, tx_data);
    end
    step();
    req0_valid = 1'b0;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_release: got %b expected 00", grant);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    tx_ready   = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hC0; req1_last = 1'b0;
    step();
    step();
    reset_reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, tx_valid, req0_ready, req1_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_async_drop: got %b expected 00000",
               {grant, tx_valid, req0_ready, req1_ready});
    end
    step();
    reset_reset = 1'b0;
    #1;
    n_checks++;
    if ({grant, tx_valid, req1_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst_after_release: got %b expected 0000", {grant, tx_valid, req1_ready});
    end
    step();
    for (int i = 0; i < 2; i++) begin
      req1_data = 8'hD0 + 8'(i);
      req1_last = (i == 1);
      #1;
      n_checks++;
      if (grant !== 2'b10 || req1_ready !== 1'b1 || tx_data !== 8'hD0 + 8'(i)) begin
        n_fail++;
        $display("FAIL midrst_beat_%0d: got grant=%b ready=%b data=%h expected 10/1/%h",
                 i, grant, req1_ready, tx_data, 8'hD0 + 8'(i));
      end
      step();
    end
    req1_valid = 1'b0;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_done: got %b expected 00", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_alternation();
    test_no_preempt();
    test_timeout();
    test_ready_stall();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
